// File: rtl/mult_seq_unit.sv
// rtl/mult_seq_unit.sv - shift-add multiplier producing a HI/LO pair for the ALU mult opcode
module mult_seq_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] MULT_OP = 3'b011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    // Bit 0 of the running product is shifted out every iteration and never read back,
    // so only the upper 2*WIDTH-1 bits are kept in the register.
    logic [2*WIDTH-1:1] acc;
    logic [CW-1:0]      count;

    logic               accept;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;

    assign accept = start && (alu_op == MULT_OP) && (state != RUN);

    // One shift-add step: carry-out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next[2*WIDTH-1:1];
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_unit.sv
// tb/tb_mult_seq_unit.sv - self-checking bench for mult_seq_unit
module tb_mult_seq_unit;

    localparam int         W   = 32;
    localparam logic [2:0] MOP = 3'b011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_seq_unit #(.WIDTH(W), .MULT_OP(MOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .alu_op(alu_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           acc;
    } vec_t;

    exp_t         sb[$];
    exp_t         e;
    vec_t         vecs[7];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pending expectation.
    always begin
        @(posedge clk);
        #1;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("latency", 64'(cycle), 64'(e.cyc));
            end
        end
    end

    task automatic drive_accept(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [W-1:0] ehi, input logic [W-1:0] elo);
        start  = 1'b1;
        alu_op = MOP;
        a      = ia;
        b      = ib;
        sb.push_back('{ehi, elo, cycle + 1 + W});
    endtask

    task automatic release_inputs();
        start  = 1'b0;
        alu_op = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic wait_done(input logic [W-1:0] ehi, input logic [W-1:0] elo, input int exp_busy);
        int n = 0;
        int busy_n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            n++;
            @(negedge clk);
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end else begin
            check("busy_at_done", 64'(busy), 64'd0);
            check("busy_cycles", 64'(busy_n), 64'(exp_busy));
        end
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic do_mult(input vec_t v);
        int busy_seen = 0;
        @(negedge clk);
        if (v.acc) begin
            drive_accept(v.a, v.b, v.hi, v.lo);
            @(negedge clk);
            release_inputs();
            wait_done(v.hi, v.lo, W);
        end else begin
            start  = 1'b1;
            alu_op = v.op;
            a      = v.a;
            b      = v.b;
            @(negedge clk);
            release_inputs();
            repeat (40) begin
                if (busy !== 1'b0) busy_seen++;
                @(negedge clk);
            end
            check("ignored_busy", 64'(busy_seen), 64'd0);
            check("ignored_hi", 64'(hi), 64'(last_hi));
            check("ignored_lo", 64'(lo), 64'(last_lo));
        end
    endtask

    initial begin
        logic [63:0] p;
        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = 3'b000;
        a      = '0;
        b      = '0;

        vecs[0] = '{MOP,    32'd3,        32'd5,        32'h0,        32'hF,        1'b1};
        vecs[1] = '{MOP,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
        vecs[2] = '{MOP,    32'h80000000, 32'd2,        32'h1,        32'h0,        1'b1};
        vecs[3] = '{3'b000, 32'd7,        32'd9,        32'h0,        32'h0,        1'b0};
        vecs[4] = '{MOP,    32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b1};
        vecs[5] = '{MOP,    32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{3'b111, 32'd1,        32'd1,        32'h0,        32'h0,        1'b0};
        p = 64'(vecs[5].a) * 64'(vecs[5].b);
        vecs[5].hi = p[63:32];
        vecs[5].lo = p[31:0];

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_mult(vecs[i]);

        // Start pulse mid-run must not disturb the 6*7 in flight.
        @(negedge clk);
        drive_accept(32'd6, 32'd7, 32'h0, 32'h2A);
        @(negedge clk);
        release_inputs();
        repeat (9) @(negedge clk);
        start  = 1'b1;
        alu_op = MOP;
        a      = 32'd100;
        b      = 32'd100;
        @(negedge clk);
        release_inputs();
        wait_done(32'h0, 32'h2A, W - 10);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-run aborts with no done and clears hi/lo at once.
        drive_accept(32'h1234, 32'h10, 32'h0, 32'h0);
        void'(sb.pop_back());
        @(negedge clk);
        release_inputs();
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_mult('{MOP, 32'd2, 32'd2, 32'h0, 32'h4, 1'b1});

        // Back-to-back: new request sampled in the DONE cycle.
        do_mult('{MOP, 32'd5, 32'd5, 32'h0, 32'd25, 1'b1});
        drive_accept(32'd10, 32'd10, 32'h0, 32'd100);
        @(negedge clk);
        release_inputs();
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done", 64'(done), 64'd0);
        wait_done(32'h0, 32'd100, W);

        repeat (40) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_unit.md
Name: mult_seq_unit

Overview:
- Multi-cycle shift-add multiplier that services the ALU's mult operation code (alu_op = 3'b011).
- The 1-bit ALU slice only reserves this code. This block is the responder that produces the actual product.
- Sits beside the 32-bit ALU in the miniMIPS datapath and writes a MIPS-style HI/LO result pair.
- Control issues a start pulse with alu_op and operands, stalls on busy, and reads hi/lo when done pulses.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- MULT_OP, 3'b011, alu_op code that this block accepts.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled on the rising edge.
- alu_op  input  3  operation code; a request is accepted only when alu_op == MULT_OP.
- a  input  WIDTH  multiplicand (unsigned).
- b  input  WIDTH  multiplier (unsigned).
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when hi/lo hold a new result.
- hi  output  WIDTH  upper half of the product.
- lo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, internal counter/accumulator cleared. Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- Accept condition: start==1 && alu_op==MULT_OP && state is IDLE or DONE. An accepted request at edge E0 does the following:
  - latches a into the multiplicand register and b into the multiplier register;
  - clears the accumulator, sets count=0 and state=RUN;
  - busy=1 from E0 onward.
- start with any other alu_op is ignored; state and outputs are unchanged.
- start while in RUN is ignored; operands are not re-latched.
- RUN, one iteration per edge E1..E_WIDTH:
  - if multiplier[0]==1, upper accumulator half += multiplicand, keeping the carry-out as bit 2*WIDTH;
  - the {carry, accumulator} is then shifted right by 1, multiplier shifts right by 1, and count increments.
- At edge E_WIDTH (count reaches WIDTH-1 before that edge):
  - hi/lo are loaded with the final 2*WIDTH product;
  - state=DONE, busy=0, done=1.
- Latency: done is high in exactly the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accept edge.
- DONE lasts exactly one cycle, then returns to IDLE and done returns to 0. A valid start sampled in DONE is accepted (back-to-back, no idle bubble); done still drops.
- hi/lo hold their last completed result until the next completion or reset. They do not change during RUN.
- Arithmetic is unsigned and exact for all operands. Overflow is impossible because the product fits in 2*WIDTH bits.
- Operands a/b may change freely after the accept edge without affecting the result.

Test Plan:
- Reset, then start, alu_op=3'b011, a=3, b=5 -> busy=1 for 32 cycles, then done pulses for 1 cycle with hi=0x00000000, lo=0x0000000F, busy=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 exactly 32 cycles after accept; a=0x80000000, b=2 -> hi=0x00000001, lo=0x00000000.
- start with alu_op=3'b000 (add), a=7, b=9 -> busy stays 0, no done, hi/lo keep their previous values.
- Accept 6*7, then pulse start with a=100, b=100 at cycle 10 of RUN -> ignored; result hi=0, lo=0x0000002A at the original latency.
- Drive rst_n low at cycle 15 of a 0x1234*0x10 run -> busy=0, done=0, hi=lo=0 immediately. After release, a fresh 2*2 gives lo=4.
- Back-to-back: start asserted during the done cycle with a=10, b=10 -> accepted; busy=1 next cycle, second done 32 cycles later with lo=100.
